// File: rtl/mem_arbiter.sv
// Shares one data-memory port between the CPU data port (m0) and the loader/DMA engine (m1).
// Latency: the grant and memory drive are combinational in the request cycle; read data returns RD_LATENCY cycles later.
// Backpressure: a master that is not granted holds its request until it is; under contention the burst cap alternates ownership.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // master 0: CPU data port
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  // master 1: UART loader / DMA
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  // memory side
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_in,
  output logic              o_mem_load,
  input  logic [DATA_W-1:0] i_mem_out,
  output logic              o_owner
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic                  r_last_owner;
  logic [CNT_W-1:0]      r_burst_cnt;
  logic [RD_LATENCY-1:0] r_trk_vld;
  logic [RD_LATENCY-1:0] r_trk_id;

  logic w_any;
  logic w_win;
  logic w_gnt;
  logic w_win_we;
  logic w_rd_acc;

  // Pick a winner: a lone requester always wins; under contention the current
  // owner keeps the port until its burst count reaches the cap.
  always_comb begin
    w_any = i_m0_req | i_m1_req;
    if (i_m0_req && i_m1_req) begin
      w_win = (r_burst_cnt < MAX_CNT) ? r_last_owner : ~r_last_owner;
    end else begin
      w_win = i_m1_req;
    end
    // No grants are issued while reset is held, even with requests pending.
    w_gnt    = w_any & i_rst_n;
    w_win_we = w_win ? i_m1_we : i_m0_we;
    w_rd_acc = w_gnt & ~w_win_we;
  end

  // Steer the winner onto the memory port; the port idles at zero with no grant.
  always_comb begin
    o_m0_gnt      = w_gnt & ~w_win;
    o_m1_gnt      = w_gnt & w_win;
    o_mem_load    = w_gnt & w_win_we;
    o_mem_address = '0;
    o_mem_in      = '0;
    if (w_gnt) begin
      o_mem_address = w_win ? i_m1_addr  : i_m0_addr;
      o_mem_in      = w_win ? i_m1_wdata : i_m0_wdata;
    end
    // With no grant the owner output holds the last master that was granted.
    o_owner = w_gnt ? w_win : r_last_owner;
  end

  // Ownership and burst bookkeeping: an idle cycle clears the burst count,
  // a handover restarts it at one, a repeat grant saturates at the cap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_owner <= 1'b0;
      r_burst_cnt  <= '0;
    end else if (!w_any) begin
      r_burst_cnt  <= '0;
    end else if (w_win == r_last_owner) begin
      r_burst_cnt  <= (r_burst_cnt == MAX_CNT) ? MAX_CNT : r_burst_cnt + CNT_W'(1);
    end else begin
      r_last_owner <= w_win;
      r_burst_cnt  <= CNT_W'(1);
    end
  end

  // Read-return tracker: each accepted read walks down the pipe with its master
  // id so the beat leaving the last stage lines up with the memory output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_trk_vld <= '0;
      r_trk_id  <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        r_trk_vld[i] <= r_trk_vld[i-1];
        r_trk_id[i]  <= r_trk_id[i-1];
      end
      r_trk_vld[0] <= w_rd_acc;
      r_trk_id[0]  <= w_win;
    end
  end

  // Read data is broadcast to both masters; rvalid alone says whose beat it is.
  always_comb begin
    o_m0_rdata  = i_mem_out;
    o_m1_rdata  = i_mem_out;
    o_m0_rvalid = r_trk_vld[RD_LATENCY-1] & ~r_trk_id[RD_LATENCY-1];
    o_m1_rvalid = r_trk_vld[RD_LATENCY-1] &  r_trk_id[RD_LATENCY-1];
  end

endmodule
